ntt_pointwise_mul: RTL and testbench

NTT_POINTWISE_MUL -- requirements
Module: ntt_pointwise_mul

---
 rtl/ntt_pointwise_mul_pkg.sv | 23 ++
 rtl/ntt_pointwise_mul_mod_mul.sv | 54 +++++
 rtl/ntt_pointwise_mul.sv | 91 +++++++++
 tb/tb_ntt_pointwise_mul.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pointwise_mul_pkg.sv
// Shared NTT definitions: ring dimensions, modulus, Barrett constant and controller state encoding.
package ntt_pointwise_mul_pkg;

    localparam int NTT_N    = 256;
    localparam int NTT_LOGN = 8;
    localparam int NTT_DW   = 14;
    localparam int NTT_Q    = 12289;

    // floor(2^(2*dw) / q), the Barrett multiplier for full-width products
    function automatic longint unsigned barrett_const(input int dw, input int q);
        return (64'd1 << (2 * dw)) / 64'(q);
    endfunction

    localparam longint unsigned NTT_BARRETT = barrett_const(NTT_DW, NTT_Q);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } ntt_state_e;

endpackage

// File: rtl/ntt_pointwise_mul_mod_mul.sv
// Two-stage modular multiplier: full-width product, then Barrett reduction with one conditional subtract.
module mod_mul
    import ntt_pointwise_mul_pkg::*;
#(
    parameter int DW = NTT_DW,
    parameter int Q  = NTT_Q
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic          i_vld,
    output logic [DW-1:0] o_r,
    output logic          o_vld
);

    localparam int PW = 4 * DW + 1;
    localparam logic [PW-1:0] BARRETT_M = PW'(barrett_const(DW, Q));
    localparam logic [PW-1:0] Q_W       = PW'(Q);
    localparam logic [DW:0]   Q_R       = (DW + 1)'(Q);

    logic [2*DW-1:0] r_prod;
    logic            r_vld1;
    logic [DW-1:0]   r_res;
    logic            r_vld2;
    logic [PW-1:0]   w_qest;
    logic [DW:0]     w_rem;
    logic [DW:0]     w_red;

    // The quotient estimate is short by at most one for any 2*DW-bit product, so w_rem < 2*Q.
    always_comb begin
        w_qest = (PW'(r_prod) * BARRETT_M) >> (2 * DW);
        w_rem  = (DW + 1)'(PW'(r_prod) - w_qest * Q_W);
        w_red  = (w_rem >= Q_R) ? (w_rem - Q_R) : w_rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod <= '0;
            r_vld1 <= 1'b0;
            r_res  <= '0;
            r_vld2 <= 1'b0;
        end else begin
            r_prod <= (2 * DW)'(i_a) * (2 * DW)'(i_b);
            r_vld1 <= i_vld;
            r_res  <= DW'(w_red);
            r_vld2 <= r_vld1;
        end
    end

    assign o_r   = r_res;
    assign o_vld = r_vld2;

endmodule

// File: rtl/ntt_pointwise_mul.sv
// Pointwise NTT-domain product C[i] = A[i]*B[i] mod Q, streaming one coefficient per cycle.
// state | meaning: IDLE wait for enable | RUN issue reads 0..N-1 | DRAIN flush pipeline | FIN done pulse
module ntt_pointwise_mul
    import ntt_pointwise_mul_pkg::*;
#(
    parameter int N    = NTT_N,
    parameter int LOGN = NTT_LOGN,
    parameter int DW   = NTT_DW,
    parameter int Q    = NTT_Q
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            enable,
    output logic            busy,
    output logic            done,
    output logic [LOGN-1:0] a_addr,
    input  logic [DW-1:0]   a_rdata,
    output logic [LOGN-1:0] b_addr,
    input  logic [DW-1:0]   b_rdata,
    output logic [LOGN-1:0] c_addr,
    output logic [DW-1:0]   c_wdata,
    output logic            c_we
);

    localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

    ntt_state_e      r_state;
    ntt_state_e      w_state_nxt;
    logic [LOGN-1:0] r_rd_addr;
    logic [LOGN-1:0] r_wr_addr;
    logic            r_rd_vld;
    logic            w_mm_vld;
    logic [DW-1:0]   w_mm_r;
    logic            w_we;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (enable) w_state_nxt = ST_RUN;
            ST_RUN:   if (r_rd_addr == LAST) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_we && r_wr_addr == LAST) w_state_nxt = ST_FIN;
            ST_FIN:   w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == ST_RUN) || (r_state == ST_DRAIN);
        done = (r_state == ST_FIN);
        w_we = w_mm_vld && busy;
    end

    // RAM read data lags the address by one cycle, so the multiplier valid is the delayed issue flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_addr <= '0;
            r_rd_vld  <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_rd_addr <= (r_state == ST_RUN) ? r_rd_addr + 1'b1 : '0;
            r_rd_vld  <= (r_state == ST_RUN);
            if (w_we)                      r_wr_addr <= r_wr_addr + 1'b1;
            else if (r_state == ST_IDLE)   r_wr_addr <= '0;
        end
    end

    mod_mul #(
        .DW (DW),
        .Q  (Q)
    ) u_mod_mul (
        .clk   (clk),
        .rst_n (rst),
        .i_a   (a_rdata),
        .i_b   (b_rdata),
        .i_vld (r_rd_vld),
        .o_r   (w_mm_r),
        .o_vld (w_mm_vld)
    );

    assign a_addr  = r_rd_addr;
    assign b_addr  = r_rd_addr;
    assign c_addr  = r_wr_addr;
    assign c_wdata = w_mm_r;
    assign c_we    = w_we;

endmodule

// File: tb/tb_ntt_pointwise_mul.sv
// Directed and random checks of the pointwise multiplier against behavioural RAMs and a (a*b)%Q model.
module tb_ntt_pointwise_mul;

    localparam int N    = 256;
    localparam int LOGN = 8;
    localparam int DW   = 14;
    localparam int Q    = 12289;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            enable = 1'b0;
    logic            busy, done, c_we;
    logic [LOGN-1:0] a_addr, b_addr, c_addr;
    logic [DW-1:0]   a_rdata, b_rdata, c_wdata;

    logic [DW-1:0]   mem_a [N];
    logic [DW-1:0]   mem_b [N];
    logic [DW-1:0]   mem_c [N];
    int unsigned     exp_c [N];

    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;
    int we_cnt, busy_cnt, done_cnt, first_we, done_edge, addr_err, bw_err, range_err;
    int acc;

    bit lg_busy [600];
    bit lg_done [600];
    bit lg_we   [600];

    ntt_pointwise_mul #(.N(N), .LOGN(LOGN), .DW(DW), .Q(Q)) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .busy    (busy),
        .done    (done),
        .a_addr  (a_addr),
        .a_rdata (a_rdata),
        .b_addr  (b_addr),
        .b_rdata (b_rdata),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_we    (c_we)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        a_rdata <= mem_a[a_addr];
        b_rdata <= mem_b[b_addr];
    end

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic clr();
        we_cnt = 0; busy_cnt = 0; done_cnt = 0; first_we = -1; done_edge = -1;
        addr_err = 0; bw_err = 0; range_err = 0;
    endtask

    task automatic set_exp();
        for (int i = 0; i < N; i++)
            exp_c[i] = (int'(mem_a[i]) * int'(mem_b[i])) % Q;
    endtask

    // One sample per cycle, away from the rising edge; cyc+1 is the edge that commits this cycle.
    task automatic sample();
        @(negedge clk); #1;
        if (c_we === 1'b1) begin
            if (int'(c_addr) != (we_cnt % N)) addr_err++;
            if (int'(c_wdata) >= Q) range_err++;
            mem_c[c_addr] = c_wdata;
            if (busy !== 1'b1) bw_err++;
            if (we_cnt == 0) first_we = cyc + 1;
            we_cnt++;
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            done_edge = cyc + 1;
            if (busy === 1'b1) bw_err++;
        end
    endtask

    task automatic run_op(input string tag, input int p0, input int p1, input int p2, input bit chk_data);
        int rc;
        int mism;
        for (int i = 0; i < N; i++) mem_c[i] = '1;
        clr();
        @(negedge clk); #1;
        enable = 1'b1;
        acc = cyc + 1;
        for (int k = 0; k < N + 40; k++) begin
            sample();
            rc = cyc - acc;
            enable = (rc == p0) || (rc == p1) || (rc == p2);
            if (done_cnt > 0 && cyc >= done_edge + 2) break;
        end
        enable = 1'b0;
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_we_cnt"}, we_cnt, N);
        chk({tag, "_first_we_lat"}, first_we - acc, 4);
        chk({tag, "_done_lat"}, done_edge - acc, N + 4);
        chk({tag, "_busy_cycles"}, busy_cnt, N + 3);
        chk({tag, "_addr_order"}, addr_err, 0);
        chk({tag, "_busy_overlap"}, bw_err, 0);
        chk({tag, "_range"}, range_err, 0);
        if (chk_data) begin
            mism = 0;
            for (int i = 0; i < N; i++) if (int'(mem_c[i]) != exp_c[i]) mism++;
            chk({tag, "_data_mism"}, mism, 0);
        end
    endtask

    initial begin
        int nd, d0, d1, w0, w1;

        for (int i = 0; i < N; i++) begin mem_a[i] = '0; mem_b[i] = '0; mem_c[i] = '0; end

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", c_we, 0);
        chk("rst_a_addr", a_addr, 0);
        chk("rst_b_addr", b_addr, 0);
        chk("rst_c_addr", c_addr, 0);
        @(negedge clk); #1;
        rst = 1'b1;

        // Ramp: A=1, B=i gives C=i
        for (int i = 0; i < N; i++) begin mem_a[i] = 14'd1; mem_b[i] = DW'(i); end
        set_exp();
        run_op("ramp", -1, -1, -1, 1'b1);
        chk("ramp_c255", mem_c[255], 255);
        chk("ramp_c77", mem_c[77], 77);

        // (Q-1)^2 = 1 mod Q
        for (int i = 0; i < N; i++) begin mem_a[i] = 14'd12288; mem_b[i] = 14'd12288; end
        set_exp();
        run_op("qm1sq", -1, -1, -1, 1'b1);
        chk("qm1sq_c17", mem_c[17], 1);

        // 2*6145 = 12290 = 1 mod Q
        for (int i = 0; i < N; i++) begin mem_a[i] = 14'd2; mem_b[i] = 14'd6145; end
        set_exp();
        run_op("two_x", -1, -1, -1, 1'b1);
        chk("two_x_c200", mem_c[200], 1);

        // Zero operand
        for (int i = 0; i < N; i++) begin mem_a[i] = 14'd0; mem_b[i] = DW'(i * 48); end
        set_exp();
        run_op("zero", -1, -1, -1, 1'b1);
        chk("zero_c99", mem_c[99], 0);

        // Hand-computed vectors in the first four slots
        for (int i = 0; i < N; i++) begin mem_a[i] = DW'(i); mem_b[i] = 14'd1; end
        mem_a[0] = 14'd100;   mem_b[0] = 14'd200;
        mem_a[1] = 14'd12288; mem_b[1] = 14'd2;
        mem_a[2] = 14'd111;   mem_b[2] = 14'd111;
        mem_a[3] = 14'd5000;  mem_b[3] = 14'd5000;
        set_exp();
        run_op("vec", -1, -1, -1, 1'b1);
        chk("vec_100x200", mem_c[0], 7711);
        chk("vec_qm1x2", mem_c[1], 12287);
        chk("vec_111sq", mem_c[2], 32);
        chk("vec_5000sq", mem_c[3], 4174);
        chk("vec_c200", mem_c[200], 200);

        // Out-of-range operands: value is don't-care but must stay below Q
        for (int i = 0; i < N; i++) begin mem_a[i] = 14'h3FFF - DW'(i); mem_b[i] = 14'h3FFF; end
        run_op("oor", -1, -1, -1, 1'b0);

        // Random operands
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++) begin
                mem_a[i] = DW'($urandom_range(Q - 1, 0));
                mem_b[i] = DW'($urandom_range(Q - 1, 0));
            end
            set_exp();
            run_op($sformatf("rnd%0d", r), -1, -1, -1, 1'b1);
        end

        // Stray enables mid-run and in FIN are ignored (expected data is the last random set)
        run_op("stray_en", 5, 100, 259, 1'b1);

        // Reset in the middle of a run
        clr();
        @(negedge clk); #1;
        enable = 1'b1;
        acc = cyc + 1;
        for (int k = 0; k < N + 40; k++) begin
            sample();
            enable = 1'b0;
            if (cyc - acc == 120) break;
        end
        chk("midrst_pre_we", we_cnt, 118);
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_we", c_we, 0);
        chk("midrst_done", done, 0);
        chk("midrst_a_addr", a_addr, 0);
        chk("midrst_c_addr", c_addr, 0);
        clr();
        repeat (2) sample();
        rst = 1'b1;
        repeat (300) sample();
        chk("midrst_no_done", done_cnt, 0);
        chk("midrst_no_we", we_cnt, 0);
        chk("midrst_no_busy", busy_cnt, 0);
        for (int i = 0; i < N; i++) begin
            mem_a[i] = DW'($urandom_range(Q - 1, 0));
            mem_b[i] = DW'($urandom_range(Q - 1, 0));
        end
        set_exp();
        run_op("post_rst", -1, -1, -1, 1'b1);

        // Enable held high: back-to-back runs
        @(negedge clk); #1;
        enable = 1'b1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk); #1;
            lg_busy[k] = busy;
            lg_done[k] = done;
            lg_we[k]   = c_we;
        end
        enable = 1'b0;
        nd = 0; d0 = -1; d1 = -1; w0 = 0; w1 = 0;
        for (int k = 0; k < 600; k++) begin
            if (lg_done[k]) begin
                if (nd == 0) d0 = k;
                else if (nd == 1) d1 = k;
                nd++;
            end
            if (lg_we[k] && nd == 0) w0++;
            if (lg_we[k] && nd == 1) w1++;
        end
        chk("b2b_ndone", nd, 2);
        chk("b2b_period", d1 - d0, N + 5);
        chk("b2b_we_run1", w0, N);
        chk("b2b_we_run2", w1, N);
        if (d0 >= 0 && d0 + 2 < 600) begin
            chk("b2b_idle_after_done0", lg_busy[d0 + 1], 0);
            chk("b2b_busy_after_done0", lg_busy[d0 + 2], 1);
            chk("b2b_no_we_done0", lg_we[d0], 0);
            chk("b2b_no_we_idle0", lg_we[d0 + 1], 0);
        end else begin
            chk("b2b_done0_found", d0, 0);
        end
        if (d1 >= 0 && d1 + 2 < 600) begin
            chk("b2b_idle_after_done1", lg_busy[d1 + 1], 0);
            chk("b2b_busy_after_done1", lg_busy[d1 + 2], 1);
        end else begin
            chk("b2b_done1_found", d1, 0);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
